// File: rtl/frame_loader_pkg.sv
// Shared constants for the frame loader: panel geometry, pixel packing and FSM encodings.
package frame_loader_pkg;

  localparam int unsigned ROWS            = 8;
  localparam int unsigned COLUMNS         = 32;
  localparam int unsigned PIXEL_W         = 24;
  localparam int unsigned BYTES_PER_PIXEL = PIXEL_W / 8;
  localparam int unsigned ROW_W           = $clog2(ROWS);
  localparam int unsigned COL_W           = $clog2(COLUMNS);
  localparam int unsigned STATE_W         = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD      = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_FLIP = 2'd2;

  // Counter width that stays legal when only one value is needed.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_loader_pixel_packer.sv
// Assembles MSB-first bytes into pixels; start restarts at byte 0, flush drops a partial pixel.
module frame_loader_pixel_packer
  import frame_loader_pkg::*;
#(
  parameter int unsigned width = PIXEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             accept_i,
  input  logic             start_i,
  input  logic             flush_i,
  output logic [width-1:0] pixel_c,
  output logic             done_c
);

  localparam int unsigned BPP   = width / 8;
  localparam int unsigned CNT_W = cnt_width(BPP);

  logic [width-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;

  // A byte arriving with start is byte 0 regardless of what was pending.
  assign cnt_eff = start_i ? '0 : cnt_q;
  assign done_c  = accept_i && (cnt_eff == CNT_W'(BPP - 1));
  assign pixel_c = (shift_q << 8) | width'(data_i);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept_i) begin
      shift_d = pixel_c;
      cnt_d   = done_c ? '0 : cnt_eff + CNT_W'(1);
    end else if (start_i) begin
      cnt_d = '0;
    end
    if (flush_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Loads SPI bytes into the display back buffer and flips buffers only at a driver frame boundary.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter int unsigned rows    = ROWS,
  parameter int unsigned columns = COLUMNS,
  parameter int unsigned width   = PIXEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 load_data,
  input  logic                       load_valid,
  input  logic                       load_sot,
  input  logic                       load_eot,
  input  logic                       frame_complete,
  output logic                       mem_wen,
  output logic [$clog2(rows)-1:0]    mem_wrow,
  output logic [$clog2(columns)-1:0] mem_wcol,
  output logic [width-1:0]           mem_wdata,
  output logic                       mem_flip,
  output logic                       busy,
  output logic                       frame_short,
  output logic                       frame_overrun
);

  localparam int unsigned RW = $clog2(rows);
  localparam int unsigned CW = $clog2(columns);

  logic [STATE_W-1:0] state_q, state_d;
  logic [RW-1:0]      row_q, row_d, wrow_q, wrow_d, row_eff;
  logic [CW-1:0]      col_q, col_d, wcol_q, wcol_d, col_eff;
  logic [width-1:0]   wdata_q, wdata_d;
  logic               full_q, full_d, full_eff;
  logic               wen_q, wen_d, flip_q, flip_d, busy_q, busy_d;
  logic               short_q, short_d, over_q, over_d;
  logic               accept_c, start_c, flush_c, write_c, last_addr_c, pix_done_c;
  logic [width-1:0]   pixel_c;

  assign accept_c = load_valid && (state_q == ST_LOAD || (state_q == ST_IDLE && load_sot));
  assign start_c  = load_sot && (state_q != ST_WAIT_FLIP);
  assign flush_c  = load_eot && !load_sot && (state_q == ST_LOAD);

  frame_loader_pixel_packer #(.width(width)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .data_i   (load_data),
    .accept_i (accept_c),
    .start_i  (start_c),
    .flush_i  (flush_c),
    .pixel_c  (pixel_c),
    .done_c   (pix_done_c)
  );

  // A start cycle sees the frame counters as already cleared.
  assign row_eff     = start_c ? '0 : row_q;
  assign col_eff     = start_c ? '0 : col_q;
  assign full_eff    = start_c ? 1'b0 : full_q;
  assign write_c     = pix_done_c && !full_eff;
  assign last_addr_c = (row_eff == RW'(rows - 1)) && (col_eff == CW'(columns - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    full_d  = full_q;
    wen_d   = 1'b0;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    wdata_d = wdata_q;
    flip_d  = flip_q;
    short_d = short_q;
    over_d  = over_q;

    if (start_c) begin
      state_d = ST_LOAD;
      row_d   = '0;
      col_d   = '0;
      full_d  = 1'b0;
      short_d = 1'b0;
      over_d  = 1'b0;
    end

    if (write_c) begin
      wen_d   = 1'b1;
      wrow_d  = row_eff;
      wcol_d  = col_eff;
      wdata_d = pixel_c;
      if (col_eff == CW'(columns - 1)) begin
        col_d = '0;
        if (row_eff == RW'(rows - 1)) begin
          row_d  = '0;
          full_d = 1'b1;
        end else begin
          row_d = row_eff + RW'(1);
        end
      end else begin
        col_d = col_eff + CW'(1);
      end
    end

    if (pix_done_c && full_eff) begin
      over_d = 1'b1;
    end

    case (state_q)
      ST_LOAD: begin
        if (flush_c) begin
          state_d = ST_WAIT_FLIP;
          short_d = !(full_q || (write_c && last_addr_c));
        end
      end
      ST_WAIT_FLIP: begin
        if (frame_complete) begin
          flip_d  = ~flip_q;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      full_q  <= 1'b0;
      wen_q   <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wdata_q <= '0;
      flip_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      full_q  <= full_d;
      wen_q   <= wen_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      wdata_q <= wdata_d;
      flip_q  <= flip_d;
      busy_q  <= busy_d;
      short_q <= short_d;
      over_q  <= over_d;
    end
  end

  assign mem_wen       = wen_q;
  assign mem_wrow      = wrow_q;
  assign mem_wcol      = wcol_q;
  assign mem_wdata     = wdata_q;
  assign mem_flip      = flip_q;
  assign busy          = busy_q;
  assign frame_short   = short_q;
  assign frame_overrun = over_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: frame table plus flip-gating, restart and reset sequences.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  load_data;
  logic        load_valid, load_sot, load_eot, frame_complete;
  logic        mem_wen, mem_flip, busy, frame_short, frame_overrun;
  logic [2:0]  mem_wrow;
  logic [4:0]  mem_wcol;
  logic [23:0] mem_wdata;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [7:0]  exp_base = 8'h00;
  logic [2:0]  last_row = '0;
  logic [4:0]  last_col = '0;
  logic        exp_flip = 1'b0;

  typedef struct {
    int   n_bytes;
    int   exp_writes;
    logic exp_short;
    logic exp_over;
    int   exp_row;
    int   exp_col;
  } vec_t;

  vec_t vecs [5];

  frame_loader dut (
    .clk            (clk),
    .rst            (rst),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .load_sot       (load_sot),
    .load_eot       (load_eot),
    .frame_complete (frame_complete),
    .mem_wen        (mem_wen),
    .mem_wrow       (mem_wrow),
    .mem_wcol       (mem_wcol),
    .mem_wdata      (mem_wdata),
    .mem_flip       (mem_flip),
    .busy           (busy),
    .frame_short    (frame_short),
    .frame_overrun  (frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write must land at the next row-major address with the next expected pixel.
  always @(negedge clk) begin
    logic [7:0] b0;
    if (rst && mem_wen) begin
      b0 = exp_base + 8'(wr_cnt * 3);
      check("wr_row",  32'(mem_wrow),  32'(wr_cnt / 32));
      check("wr_col",  32'(mem_wcol),  32'(wr_cnt % 32));
      check("wr_data", 32'(mem_wdata), 32'({b0, b0 + 8'd1, b0 + 8'd2}));
      last_row = mem_wrow;
      last_col = mem_wcol;
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_valid     = 1'b0;
    load_sot       = 1'b0;
    load_eot       = 1'b0;
    frame_complete = 1'b0;
  endtask

  task automatic send_burst(input int n, input logic [7:0] base, input logic with_eot,
                            input logic fc_on_eot);
    for (int k = 0; k < n; k++) begin
      tick();
      load_valid     = 1'b1;
      load_data      = base + 8'(k);
      load_sot       = (k == 0);
      load_eot       = with_eot && (k == n - 1);
      frame_complete = fc_on_eot && (k == n - 1);
    end
    tick();
    idle();
  endtask

  task automatic flip_now();
    frame_complete = 1'b1;
    check("flip_before_fc", 32'(mem_flip), 32'(exp_flip));
    tick();
    frame_complete = 1'b0;
    exp_flip = ~exp_flip;
    check("flip_after_fc", 32'(mem_flip), 32'(exp_flip));
    check("busy_after_fc", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input logic [7:0] base);
    wr_cnt   = 0;
    exp_base = base;
    send_burst(v.n_bytes, base, 1'b1, 1'b0);
    tick();
    tick();
    check("writes",        32'(wr_cnt),        32'(v.exp_writes));
    check("frame_short",   32'(frame_short),   32'(v.exp_short));
    check("frame_overrun", 32'(frame_overrun), 32'(v.exp_over));
    check("busy_wait",     32'(busy),          32'd1);
    check("last_row",      32'(last_row),      32'(v.exp_row));
    check("last_col",      32'(last_col),      32'(v.exp_col));
  endtask

  initial begin
    vecs[0] = '{768, 256, 1'b0, 1'b0, 7, 31};
    vecs[1] = '{10,  3,   1'b1, 1'b0, 0, 2};
    vecs[2] = '{800, 256, 1'b0, 1'b1, 7, 31};
    vecs[3] = '{3,   1,   1'b1, 1'b0, 0, 0};
    vecs[4] = '{771, 256, 1'b0, 1'b1, 7, 31};

    rst       = 1'b0;
    load_data = 8'h00;
    idle();
    repeat (3) tick();
    check("rst_wen",   32'(mem_wen),       32'd0);
    check("rst_flip",  32'(mem_flip),      32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_short", 32'(frame_short),   32'd0);
    check("rst_over",  32'(frame_overrun), 32'd0);
    check("rst_addr",  32'({mem_wrow, mem_wcol}), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], 8'h00);
      flip_now();
    end

    // Flip held without frame_complete; traffic in WAIT_FLIP is ignored.
    run_frame(vecs[0], 8'h10);
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (c == 500) begin
        load_sot = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
      end else if (c == 501) begin
        idle(); load_valid = 1'b1; load_eot = 1'b1;
      end else begin
        idle();
      end
    end
    idle();
    tick();
    tick();
    check("gate_flip",   32'(mem_flip), 32'(exp_flip));
    check("gate_busy",   32'(busy),     32'd1);
    check("gate_writes", 32'(wr_cnt),   32'd256);
    flip_now();

    // Restart mid-frame; frame_complete alongside eot is ignored.
    wr_cnt   = 0;
    exp_base = 8'h00;
    send_burst(30, 8'h00, 1'b0, 1'b0);
    tick();
    check("burst1_writes", 32'(wr_cnt), 32'd10);
    wr_cnt   = 0;
    exp_base = 8'h80;
    send_burst(6, 8'h80, 1'b1, 1'b1);
    tick();
    tick();
    check("restart_writes", 32'(wr_cnt),      32'd2);
    check("restart_row",    32'(last_row),    32'd0);
    check("restart_col",    32'(last_col),    32'd1);
    check("restart_short",  32'(frame_short), 32'd1);
    check("fc_on_eot_busy", 32'(busy),        32'd1);
    check("fc_on_eot_flip", 32'(mem_flip),    32'(exp_flip));
    flip_now();

    // Reset in the middle of a load with the flip set.
    if (!exp_flip) begin
      run_frame(vecs[3], 8'h00);
      flip_now();
    end
    check("pre_reset_flip", 32'(mem_flip), 32'd1);
    wr_cnt   = 0;
    exp_base = 8'h00;
    send_burst(20, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    exp_flip = 1'b0;
    check("midrst_wen",  32'(mem_wen),  32'd0);
    check("midrst_flip", 32'(mem_flip), 32'd0);
    check("midrst_busy", 32'(busy),     32'd0);
    tick();
    rst = 1'b1;
    tick();
    run_frame(vecs[0], 8'h40);
    flip_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
